// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM state encoding and byte-lane helpers for the lookup-table memory responder.
package mem_ctrl_pkg;

  localparam int unsigned DATA_BUS         = 32;
  localparam int unsigned ADDR_BUS         = 32;
  localparam int unsigned MAX_ACCESS_BYTES = 4;
  localparam int unsigned WIDTH_W          = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_WR0,
    ST_WR1,
    ST_DONE,
    ST_CFG
  } state_t;

  // Low-aligned byte mask covering n bytes (n already clamped to 0..4).
  function automatic logic [DATA_BUS-1:0] byte_mask(input logic [WIDTH_W-1:0] n);
    logic [DATA_BUS-1:0] m;
    case (n)
      3'd1:    m = 32'h0000_00FF;
      3'd2:    m = 32'h0000_FFFF;
      3'd3:    m = 32'h00FF_FFFF;
      3'd4:    m = 32'hFFFF_FFFF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port word RAM: one-cycle registered read, full-word write, read-first on collision.
module sram_sp #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WORD_W-1:0]        i_wdata,
  output logic [WORD_W-1:0]        o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-addressed request responder over a word RAM: 1-4 byte unaligned reads and
// read-modify-write writes (returning old contents), plus a control-plane word write port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_BUS,
  parameter int unsigned DATA_W = DATA_BUS,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_ce_i,
  input  logic                     mem_we_i,
  input  logic [ADDR_W-1:0]        mem_addr_i,
  input  logic [3:0]               mem_width_i,
  input  logic [DATA_W-1:0]        mem_data_i,
  output logic [DATA_W-1:0]        mem_data_o,
  output logic                     mem_ready_o,
  input  logic                     cfg_we_i,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr_i,
  input  logic [DATA_W-1:0]        cfg_data_i,
  output logic                     cfg_ack_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t               r_state;
  logic                 r_we;
  logic                 r_span2;
  logic [1:0]           r_lane;
  logic [WIDTH_W-1:0]   r_width;
  logic [IDX_W-1:0]     r_w0_idx;
  logic [IDX_W-1:0]     r_w1_idx;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_w0;
  logic [DATA_W-1:0]    r_w1;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_ready;
  logic                 r_cfg_ack;

  logic [WIDTH_W-1:0]   w_width;
  logic                 w_span2;
  logic [IDX_W-1:0]     w_req_idx;
  logic [4:0]           w_shift;
  logic [DATA_W-1:0]    w_bmask;
  logic [2*DATA_W-1:0]  w_mask64;
  logic [2*DATA_W-1:0]  w_new64;
  logic [DATA_W-1:0]    w_w0;
  logic [DATA_W-1:0]    w_w1;
  logic [DATA_W-1:0]    w_asm;
  logic                 w_ram_we;
  logic [IDX_W-1:0]     w_ram_addr;
  logic [DATA_W-1:0]    w_ram_wdata;
  logic [DATA_W-1:0]    w_ram_rdata;
  logic                 w_unused_addr;

  // Request decode: clamp width, detect a second-word access, pick the word index.
  assign w_width   = (mem_width_i > 4'(MAX_ACCESS_BYTES)) ? WIDTH_W'(MAX_ACCESS_BYTES)
                                                          : mem_width_i[WIDTH_W-1:0];
  assign w_span2   = (4'(mem_addr_i[1:0]) + 4'(w_width)) > 4'(MAX_ACCESS_BYTES);
  assign w_req_idx = mem_addr_i[IDX_W+1:2];
  assign w_unused_addr = ^mem_addr_i[ADDR_W-1:IDX_W+2];

  // Lane extract/merge over the two-word window {w1, w0}.
  assign w_shift  = {r_lane, 3'b000};
  assign w_bmask  = byte_mask(r_width);
  assign w_mask64 = {{DATA_W{1'b0}}, w_bmask} << w_shift;
  assign w_new64  = ({r_w1, r_w0} & ~w_mask64)
                  | (({{DATA_W{1'b0}}, r_wdata} << w_shift) & w_mask64);

  // The word arriving from RAM this cycle is used before it lands in its capture register.
  assign w_w0  = (r_state == ST_RD0) ? w_ram_rdata : r_w0;
  assign w_w1  = (r_state == ST_RD1) ? w_ram_rdata : r_w1;
  assign w_asm = DATA_W'({w_w1, w_w0} >> w_shift) & w_bmask;

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = r_w0_idx;
    w_ram_wdata = w_new64[DATA_W-1:0];
    case (r_state)
      ST_IDLE: begin
        if (cfg_we_i) begin
          w_ram_we    = 1'b1;
          w_ram_addr  = cfg_addr_i;
          w_ram_wdata = cfg_data_i;
        end else begin
          w_ram_addr = w_req_idx;
        end
      end
      ST_RD0:  w_ram_addr = r_w1_idx;
      ST_WR0:  w_ram_we   = 1'b1;
      ST_WR1: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_w1_idx;
        w_ram_wdata = w_new64[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
    if (rst) w_ram_we = 1'b0;
  end

  sram_sp #(
    .DEPTH  (DEPTH),
    .WORD_W (DATA_W)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Access sequencer; ready/ack/data are set on entry to DONE/CFG so they are visible there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_cfg_ack <= 1'b0;
    end else begin
      r_ready   <= 1'b0;
      r_cfg_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_we_i) begin
            r_cfg_ack <= 1'b1;
            r_state   <= ST_CFG;
          end else if (mem_ce_i) begin
            r_we     <= mem_we_i;
            r_lane   <= mem_addr_i[1:0];
            r_width  <= w_width;
            r_span2  <= w_span2;
            r_wdata  <= mem_data_i;
            r_w0_idx <= w_req_idx;
            r_w1_idx <= IDX_W'(w_req_idx + 1'b1);
            if (w_width == '0) begin
              r_ready <= 1'b1;
              r_rdata <= '0;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_RD0;
            end
          end
        end
        ST_RD0: begin
          r_w0 <= w_ram_rdata;
          if (r_span2) begin
            r_state <= ST_RD1;
          end else if (r_we) begin
            r_state <= ST_WR0;
          end else begin
            r_ready <= 1'b1;
            r_rdata <= w_asm;
            r_state <= ST_DONE;
          end
        end
        ST_RD1: begin
          r_w1 <= w_ram_rdata;
          if (r_we) begin
            r_state <= ST_WR0;
          end else begin
            r_ready <= 1'b1;
            r_rdata <= w_asm;
            r_state <= ST_DONE;
          end
        end
        ST_WR0: begin
          if (r_span2) begin
            r_state <= ST_WR1;
          end else begin
            r_ready <= 1'b1;
            r_rdata <= w_asm;
            r_state <= ST_DONE;
          end
        end
        ST_WR1: begin
          r_ready <= 1'b1;
          r_rdata <= w_asm;
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_CFG:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_data_o  = r_rdata;
  assign mem_ready_o = r_ready;
  assign cfg_ack_o   = r_cfg_ack;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboarded bench for mem_ctrl: a byte-array reference model predicts returned data and
// completion cycle; a negedge monitor pops expectations whenever mem_ready_o pulses.
module tb_mem_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BYTES = DEPTH * 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mem_ce_i;
  logic             mem_we_i;
  logic [31:0]      mem_addr_i;
  logic [3:0]       mem_width_i;
  logic [31:0]      mem_data_i;
  logic [31:0]      mem_data_o;
  logic             mem_ready_o;
  logic             cfg_we_i;
  logic [IDX_W-1:0] cfg_addr_i;
  logic [31:0]      cfg_data_i;
  logic             cfg_ack_o;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ce_i    (mem_ce_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_width_i (mem_width_i),
    .mem_data_i  (mem_data_i),
    .mem_data_o  (mem_data_o),
    .mem_ready_o (mem_ready_o),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_data_i  (cfg_data_i),
    .cfg_ack_o   (cfg_ack_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_m [BYTES];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Behavioural access: byte list from addr (mod memory size), old bytes returned, latency by rule.
  task automatic model_access(input logic [31:0] a, input logic [3:0] w, input logic we,
                              input logic [31:0] d, output logic [31:0] old, output int lat);
    int n;
    int base;
    n    = (w > 4) ? 4 : int'(w);
    base = int'(a % BYTES);
    old  = '0;
    for (int k = 0; k < n; k++) begin
      int b;
      b = (base + k) % BYTES;
      old[8*k +: 8] = mem_m[b];
      if (we) mem_m[b] = d[8*k +: 8];
    end
    if (n == 0)                   lat = 1;
    else if ((base % 4) + n > 4)  lat = we ? 5 : 3;
    else                          lat = we ? 3 : 2;
  endtask

  task automatic model_cfg(input int idx, input logic [31:0] d);
    for (int k = 0; k < 4; k++) mem_m[idx*4 + k] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {mem_m[idx*4+3], mem_m[idx*4+2], mem_m[idx*4+1], mem_m[idx*4]};
  endfunction

  always @(negedge clk) begin
    if (!rst && mem_ready_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got data %h expected no completion", mem_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", mem_data_o, e.data);
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_ready();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = mem_ready_o;
    end
    mem_ce_i = 1'b0;
    if (!seen) begin
      fail_now("ready_timeout");
      exp_q.delete();
    end
    tick();
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] w, input logic we,
                        input logic [31:0] d);
    exp_t e;
    int   lat;
    model_access(a, w, we, d, e.data, lat);
    e.cyc = cyc + lat;
    exp_q.push_back(e);
    mem_addr_i  = a;
    mem_width_i = w;
    mem_we_i    = we;
    mem_data_i  = d;
    mem_ce_i    = 1'b1;
    wait_ready();
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] d);
    int start;
    bit seen;
    start      = cyc;
    seen       = 1'b0;
    cfg_addr_i = IDX_W'(idx);
    cfg_data_i = d;
    cfg_we_i   = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = cfg_ack_o;
    end
    cfg_we_i = 1'b0;
    if (!seen) fail_now("cfg_ack_timeout");
    else       chk("cfg_ack_latency", 32'(cyc - start), 32'd1);
    model_cfg(idx, d);
    tick();
  endtask

  // cfg and request together: cfg wins, request then completes and sees the new word.
  task automatic test_collision();
    int          start;
    int          lat;
    bit          seen;
    exp_t        e;
    logic [31:0] nd;
    nd          = $urandom();
    start       = cyc;
    seen        = 1'b0;
    mem_addr_i  = 32'h28;
    mem_width_i = 4'd4;
    mem_we_i    = 1'b0;
    mem_data_i  = '0;
    mem_ce_i    = 1'b1;
    cfg_addr_i  = IDX_W'(10);
    cfg_data_i  = nd;
    cfg_we_i    = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = cfg_ack_o;
    end
    cfg_we_i = 1'b0;
    if (!seen) fail_now("collision_ack_timeout");
    else       chk("collision_ack_latency", 32'(cyc - start), 32'd1);
    model_cfg(10, nd);
    model_access(32'h28, 4'd4, 1'b0, '0, e.data, lat);
    e.cyc = start + 2 + lat;
    exp_q.push_back(e);
    wait_ready();
  endtask

  // cfg raised while a read sits in RD0: ack only after the read's DONE.
  task automatic test_cfg_in_rd0();
    int          start;
    int          ack_cyc;
    int          lat;
    bit          seen_rdy;
    bit          seen_ack;
    exp_t        e;
    logic [31:0] nd;
    nd       = $urandom();
    start    = cyc;
    seen_rdy = 1'b0;
    seen_ack = 1'b0;
    ack_cyc  = 0;
    model_access(32'h30, 4'd4, 1'b0, '0, e.data, lat);
    e.cyc = start + lat;
    exp_q.push_back(e);
    mem_addr_i  = 32'h30;
    mem_width_i = 4'd4;
    mem_we_i    = 1'b0;
    mem_ce_i    = 1'b1;
    tick();
    cfg_addr_i = IDX_W'(12);
    cfg_data_i = nd;
    cfg_we_i   = 1'b1;
    for (int i = 0; i < 20 && !seen_ack; i++) begin
      tick();
      if (mem_ready_o) begin
        seen_rdy = 1'b1;
        mem_ce_i = 1'b0;
      end
      if (cfg_ack_o) begin
        seen_ack = 1'b1;
        ack_cyc  = cyc;
      end
    end
    cfg_we_i = 1'b0;
    mem_ce_i = 1'b0;
    if (!seen_rdy) begin
      fail_now("rd0_ready_timeout");
      exp_q.delete();
    end
    if (!seen_ack) fail_now("rd0_cfg_ack_timeout");
    else           chk("rd0_cfg_ack_cycle", 32'(ack_cyc - start), 32'd4);
    model_cfg(12, nd);
    tick();
    do_req(32'h30, 4'd4, 1'b0, '0);
  endtask

  // Reset landing in WR0 of a span2 write: outputs clear, back to IDLE, second word untouched.
  task automatic test_reset_wr0();
    mem_addr_i  = 32'h1B;
    mem_width_i = 4'd3;
    mem_we_i    = 1'b1;
    mem_data_i  = $urandom();
    mem_ce_i    = 1'b1;
    repeat (3) tick();
    rst      = 1'b1;
    mem_ce_i = 1'b0;
    tick();
    chk("midrst_ready", 32'(mem_ready_o), 32'd0);
    chk("midrst_data",  mem_data_o,       32'd0);
    chk("midrst_ack",   32'(cfg_ack_o),   32'd0);
    rst = 1'b0;
    do_req(32'h0, 4'd0, 1'b0, '0);
    cfg_write(6, model_word(6));
    do_req(32'h1C, 4'd4, 1'b0, '0);
    do_req(32'h18, 4'd4, 1'b0, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    mem_ce_i    = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_width_i = '0;
    mem_data_i  = '0;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = '0;
    cfg_data_i  = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(mem_ready_o), 32'd0);
    chk("rst_data",  mem_data_o,       32'd0);
    chk("rst_ack",   32'(cfg_ack_o),   32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) cfg_write(i, $urandom());

    cfg_write(5, 32'h4433_2211);
    do_req(32'h14, 4'd4, 1'b0, '0);
    cfg_write(6, 32'h8877_6655);
    do_req(32'h16, 4'd4, 1'b0, '0);
    do_req(32'h17, 4'd2, 1'b1, 32'h0000_BBAA);
    do_req(32'h14, 4'd4, 1'b0, '0);
    do_req(32'h18, 4'd4, 1'b0, '0);

    do_req(32'h20, 4'd0, 1'b0, '0);
    do_req(32'h21, 4'd0, 1'b1, $urandom());
    do_req(32'h20, 4'd4, 1'b0, '0);
    do_req(32'h14, 4'd9, 1'b0, '0);
    do_req(32'(BYTES - 2), 4'd4, 1'b0, '0);
    do_req(32'(BYTES - 2), 4'd4, 1'b1, $urandom());
    do_req(32'h0, 4'd4, 1'b0, '0);
    do_req(32'(BYTES - 4), 4'd4, 1'b0, '0);
    do_req(32'hFFFF_0015, 4'd3, 1'b0, '0);

    test_collision();
    test_cfg_in_rd0();
    test_reset_wr0();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0)
        cfg_write(int'($urandom_range(0, DEPTH - 1)), $urandom());
      else
        do_req($urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom());
    end

    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

- Byte-addressed memory responder for the lookup-table request interface driven by each processor's matcher.
- Accepts one request at a time on the `ce/we/addr/width/data → ready` handshake.
- Serves 1–4 byte reads and writes, aligned or unaligned, from a word-wide single-port synchronous RAM; writes are read-modify-write and return the old contents.
- A control-plane word-write port loads table entries between requests.

## Interface

Parameters:
- `ADDR_W`, default 32: request address width (byte address).
- `DATA_W`, default 32: data width; fixed at 4 bytes.
- `DEPTH`, default 4096: RAM depth in 32-bit words; power of two.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `mem_ce_i` in 1: request valid; held with all request fields stable until `mem_ready_o`.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_addr_i` in ADDR_W: byte address of the lowest byte.
- `mem_width_i` in 4: byte count.
- `mem_data_i` in 32: write data; byte k of the access is `[8k+7:8k]`.
- `mem_data_o` out 32: read data, or old contents on a write; unused upper bytes are 0.
- `mem_ready_o` out 1: one-cycle completion pulse.
- `cfg_we_i` in 1: control-plane word write request.
- `cfg_addr_i` in log2(DEPTH): word index.
- `cfg_data_i` in 32: word data.
- `cfg_ack_o` out 1: one-cycle pulse when the cfg write is committed.

## Operation

- Byte order is little-endian: address byte `a` maps to word `a>>2`, lane `a[1:0]`.
- Word index uses address bits `[log2(DEPTH)+1:2]`; higher bits are ignored.
- Width rules:
  - width 0: no RAM access, `mem_data_o`=0.
  - width 1–4: as given.
  - width >4: clamped to 4.
- `span2` = `addr[1:0] + width > 4`. The second word is `(w0+1) mod DEPTH` (wraps at the top of memory).
- FSM states: IDLE, RD0, RD1, WR0, WR1, DONE, CFG.
  - IDLE: if `cfg_we_i`, write the RAM word and go to CFG. This takes priority over `mem_ce_i`; the request waits.
  - IDLE, else if `mem_ce_i`: latch all fields. Width 0 goes to DONE. Otherwise issue a read of w0 and go to RD0.
  - RD0: capture w0. If `span2`, issue a read of w0+1 and go to RD1. Else go to WR0 if write, DONE if read.
  - RD1: capture w1. Go to WR0 if write, DONE if read.
  - WR0: write w0 merged with the new bytes in the addressed lanes. Go to WR1 if `span2`, else DONE.
  - WR1: write w1 merged. Go to DONE.
  - DONE: `mem_ready_o`=1; `mem_data_o` = bytes assembled from the captured words (pre-write values). Go to IDLE.
  - CFG: `cfg_ack_o`=1. Go to IDLE.
- `cfg_we_i` outside IDLE is stalled: the requester holds it until `cfg_ack_o`.
- `mem_ce_i` is sampled only in IDLE. A request still held high in the cycle after DONE is treated as a new access.

## Timing

- Reset values: `mem_ready_o`=0, `mem_data_o`=0, `cfg_ack_o`=0, state IDLE.
- RAM contents are not cleared by reset. No RAM write occurs in a reset cycle.
- Reset mid-operation aborts the access; a pending WR1 is dropped (partial write of w0 is possible).
- The RAM has 1-cycle read latency. All outputs are registered.
- Latencies, measured from the first cycle `mem_ce_i` is seen in IDLE (cycle 0) to `mem_ready_o`:
  - width 0: cycle 1.
  - aligned read: cycle 2.
  - span2 read: cycle 3.
  - aligned write: cycle 3.
  - span2 write: cycle 5.
- Cfg write: `cfg_ack_o` at cycle 1 if accepted in IDLE.
- `mem_data_o` holds its value until the next DONE.

## Structure

- Shared header holds the `DATA_BUS` and `ADDR_BUS` widths, the FSM state enum, and the `MAX_ACCESS_BYTES=4` constant.
- Sub-module `sram_sp`: single-port, 1-cycle read latency, full-word write enable, DEPTH×32.
- Lane extract/merge is combinational logic inside `mem_ctrl`.

## Test plan

- Cfg write word 5 = 0x44332211, then read addr 0x14, width 4 → ready at cycle 2, data 0x44332211.
- Unaligned read: words 5/6 = 0x44332211/0x88776655; read addr 0x16, width 4 → ready at cycle 3, data 0x66554433.
- Unaligned write: addr 0x17, width 2, data 0xBBAA → ready at cycle 5, returned 0x5544; words 5/6 become 0xAA332211/0x887766BB.
- Boundary: width 0 → ready at cycle 1, data 0. Width 9 at addr 0x14 behaves as width 4. Addr `(DEPTH*4-2)`, width 4 wraps to word 0.
- Collision: `cfg_we_i` and `mem_ce_i` asserted together in IDLE → cfg_ack at cycle 1 and the request completes afterwards, seeing the new data. `cfg_we_i` raised during RD0 → ack only after DONE.
- Reset asserted in WR0 of a span2 write → outputs 0 next cycle, state IDLE, w1 unchanged.
